vector_sweep_capture: RTL and testbench

//  Upstream stimulus + capture stage for the 4-input logic-function units (f1, f2, f3).
//  On start, it drives every input code 0..2^WIDTH-1 onto vec and samples the three function outputs.
//  It builds one captured truth table per function and a minterm count for each.
//  It compares each table against its expected constant and reports pass/fail per function.

---
 rtl/vector_sweep_capture_if.sv | 32 +++
 rtl/vector_sweep_capture.sv | 137 +++++++++++++
 tb/tb_vector_sweep_capture.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_sweep_capture_if.sv
// Bus between the sweep/capture stage and the logic-function units it exercises.
// The slave side is the capture stage; the master side owns start and the function outputs.
interface vector_sweep_capture_if #(
  parameter int WIDTH = 4
);
  localparam int N = 1 << WIDTH;

  logic             start;
  logic             f1_in;
  logic             f2_in;
  logic             f3_in;
  logic [WIDTH-1:0] vec;
  logic             busy;
  logic             done;
  logic [N-1:0]     tt1;
  logic [N-1:0]     tt2;
  logic [N-1:0]     tt3;
  logic [WIDTH:0]   cnt1;
  logic [WIDTH:0]   cnt2;
  logic [WIDTH:0]   cnt3;
  logic [2:0]       pass;

  modport master (
    output start, f1_in, f2_in, f3_in,
    input  vec, busy, done, tt1, tt2, tt3, cnt1, cnt2, cnt3, pass
  );

  modport slave (
    input  start, f1_in, f2_in, f3_in,
    output vec, busy, done, tt1, tt2, tt3, cnt1, cnt2, cnt3, pass
  );
endinterface

// File: rtl/vector_sweep_capture.sv
// Sweep/capture stage: walks vec through every code, optionally lets the function
// units settle, records one truth table and a ones-count per function, and
// compares each table against its expected constant once the sweep finishes.
module vector_sweep_capture #(
  parameter int                      WIDTH  = 4,
  parameter int                      SETTLE = 0,
  parameter logic [(1<<WIDTH)-1:0]   EXP1   = 16'h3232,
  parameter logic [(1<<WIDTH)-1:0]   EXP2   = 16'hCAC2,
  parameter logic [(1<<WIDTH)-1:0]   EXP3   = 16'hB0A0
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_sweep_capture_if.slave bus
);
  localparam int               N           = 1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST_CODE   = WIDTH'(N - 1);
  localparam logic [3:0]       SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam bit               NO_SETTLE   = (SETTLE == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] vec_q, vec_n;
  logic [3:0]       wcnt_q, wcnt_n;
  logic [N-1:0]     tt1_q, tt1_n, tt2_q, tt2_n, tt3_q, tt3_n;
  logic [WIDTH:0]   cnt1_q, cnt1_n, cnt2_q, cnt2_n, cnt3_q, cnt3_n;
  logic [2:0]       pass_q, pass_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  // Register the FSM and every output; reset wins over start and sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      wcnt_q  <= '0;
      tt1_q   <= '0;
      tt2_q   <= '0;
      tt3_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      cnt3_q  <= '0;
      pass_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      vec_q   <= vec_n;
      wcnt_q  <= wcnt_n;
      tt1_q   <= tt1_n;
      tt2_q   <= tt2_n;
      tt3_q   <= tt3_n;
      cnt1_q  <= cnt1_n;
      cnt2_q  <= cnt2_n;
      cnt3_q  <= cnt3_n;
      pass_q  <= pass_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Next-state and next-datapath decode; function inputs only matter in SAMPLE.
  always_comb begin
    state_n = state_q;
    vec_n   = vec_q;
    wcnt_n  = wcnt_q;
    tt1_n   = tt1_q;
    tt2_n   = tt2_q;
    tt3_n   = tt3_q;
    cnt1_n  = cnt1_q;
    cnt2_n  = cnt2_q;
    cnt3_n  = cnt3_q;
    pass_n  = pass_q;
    busy_n  = busy_q;
    done_n  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          vec_n   = '0;
          wcnt_n  = '0;
          tt1_n   = '0;
          tt2_n   = '0;
          tt3_n   = '0;
          cnt1_n  = '0;
          cnt2_n  = '0;
          cnt3_n  = '0;
          pass_n  = '0;
          busy_n  = 1'b1;
          state_n = NO_SETTLE ? S_SAMPLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt_q == SETTLE_LAST) begin
          wcnt_n  = '0;
          state_n = S_SAMPLE;
        end else begin
          wcnt_n = wcnt_q + 4'd1;
        end
      end
      S_SAMPLE: begin
        tt1_n[vec_q] = bus.f1_in;
        tt2_n[vec_q] = bus.f2_in;
        tt3_n[vec_q] = bus.f3_in;
        cnt1_n       = cnt1_q + (WIDTH+1)'(bus.f1_in);
        cnt2_n       = cnt2_q + (WIDTH+1)'(bus.f2_in);
        cnt3_n       = cnt3_q + (WIDTH+1)'(bus.f3_in);
        if (vec_q == LAST_CODE) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = {tt3_n == EXP3, tt2_n == EXP2, tt1_n == EXP1};
        end else begin
          vec_n   = vec_q + 1'b1;
          state_n = NO_SETTLE ? S_SAMPLE : S_WAIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.vec  = vec_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.tt1  = tt1_q;
  assign bus.tt2  = tt2_q;
  assign bus.tt3  = tt3_q;
  assign bus.cnt1 = cnt1_q;
  assign bus.cnt2 = cnt2_q;
  assign bus.cnt3 = cnt3_q;
  assign bus.pass = pass_q;
endmodule

// File: tb/tb_vector_sweep_capture.sv
// Bench for vector_sweep_capture: two instances (SETTLE=0 and SETTLE=3) driven by
// behavioural f1/f2/f3 units, with a scoreboard of expected sweep results.
module tb_vector_sweep_capture;
  localparam int WIDTH = 4;

  typedef enum int {M_NORMAL, M_F2_FAULT, M_TIE1} mode_t;

  typedef struct {
    mode_t       mode;
    logic [15:0] tt1;
    logic [15:0] tt2;
    logic [15:0] tt3;
    logic [4:0]  cnt1;
    logic [4:0]  cnt2;
    logic [4:0]  cnt3;
    logic [2:0]  pass;
  } vec_rec_t;

  logic  clk = 1'b0;
  logic  rst;
  mode_t mode0, mode1;
  int    checks = 0;
  int    passes = 0;
  vec_rec_t sbQ[$];
  vec_rec_t cases[4];

  vector_sweep_capture_if #(.WIDTH(WIDTH)) b0 ();
  vector_sweep_capture_if #(.WIDTH(WIDTH)) b1 ();

  vector_sweep_capture #(.WIDTH(WIDTH), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  vector_sweep_capture #(.WIDTH(WIDTH), .SETTLE(3)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  // Behavioural function units written from their minterm lists.
  function automatic logic fModel(input int fn, input logic [3:0] code, input mode_t m);
    logic r;
    if (m == M_TIE1) return 1'b1;
    case (fn)
      1:       r = code inside {4'd1, 4'd4, 4'd5, 4'd9, 4'd12, 4'd13};
      2:       r = code inside {4'd1, 4'd6, 4'd7, 4'd9, 4'd11, 4'd14, 4'd15};
      default: r = code inside {4'd5, 4'd7, 4'd12, 4'd13, 4'd15};
    endcase
    if (fn == 2 && m == M_F2_FAULT && code == 4'd11) r = 1'b0;
    return r;
  endfunction

  assign b0.f1_in = fModel(1, b0.vec, mode0);
  assign b0.f2_in = fModel(2, b0.vec, mode0);
  assign b0.f3_in = fModel(3, b0.vec, mode0);
  assign b1.f1_in = fModel(1, b1.vec, mode1);
  assign b1.f2_in = fModel(2, b1.vec, mode1);
  assign b1.f3_in = fModel(3, b1.vec, mode1);

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [3:0] getVec(input int sel);
    return (sel == 0) ? b0.vec : b1.vec;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 0) ? b0.busy : b1.busy;
  endfunction

  function automatic logic getDone(input int sel);
    return (sel == 0) ? b0.done : b1.done;
  endfunction

  task automatic setStart(input int sel, input logic v);
    if (sel == 0) b0.start = v;
    else          b1.start = v;
  endtask

  task automatic readOut(input int sel, output vec_rec_t r);
    r.mode = M_NORMAL;
    if (sel == 0) begin
      r.tt1 = b0.tt1; r.tt2 = b0.tt2; r.tt3 = b0.tt3;
      r.cnt1 = b0.cnt1; r.cnt2 = b0.cnt2; r.cnt3 = b0.cnt3; r.pass = b0.pass;
    end else begin
      r.tt1 = b1.tt1; r.tt2 = b1.tt2; r.tt3 = b1.tt3;
      r.cnt1 = b1.cnt1; r.cnt2 = b1.cnt2; r.cnt3 = b1.cnt3; r.pass = b1.pass;
    end
  endtask

  // Pulse start for one edge, queue the expected result, and confirm busy rose.
  task automatic applyStimulus(input int sel, input vec_rec_t rec);
    if (sel == 0) mode0 = rec.mode;
    else          mode1 = rec.mode;
    sbQ.push_back(rec);
    setStart(sel, 1'b1);
    @(posedge clk); #1;
    setStart(sel, 1'b0);
    checkVal($sformatf("dut%0d.busyAfterStart", sel), 32'(getBusy(sel)), 32'd1);
  endtask

  // Count edges until done; optionally pulse start at edge pulseAt to show it is ignored.
  task automatic waitDone(input int sel, input int maxCycles, input int pulseAt, output int n);
    n = 0;
    while (n < maxCycles) begin
      @(posedge clk); #1;
      n++;
      if (pulseAt != 0 && n == pulseAt - 1) setStart(sel, 1'b1);
      if (pulseAt != 0 && n == pulseAt)     setStart(sel, 1'b0);
      if (getDone(sel)) return;
    end
    checkVal($sformatf("dut%0d.doneTimeout", sel), 32'(getDone(sel)), 32'd1);
  endtask

  // Pop the oldest expectation and compare it with what the instance captured.
  task automatic checkOutput(input int sel, input int n, input int expCycles, input bit followUp);
    vec_rec_t e, a;
    string    p;
    p = $sformatf("dut%0d", sel);
    if (sbQ.size() == 0) begin
      checkVal({p, ".scoreboardEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = sbQ.pop_front();
    readOut(sel, a);
    checkVal({p, ".cycles"}, 32'(n), 32'(expCycles));
    checkVal({p, ".tt1"}, 32'(a.tt1), 32'(e.tt1));
    checkVal({p, ".tt2"}, 32'(a.tt2), 32'(e.tt2));
    checkVal({p, ".tt3"}, 32'(a.tt3), 32'(e.tt3));
    checkVal({p, ".cnt1"}, 32'(a.cnt1), 32'(e.cnt1));
    checkVal({p, ".cnt2"}, 32'(a.cnt2), 32'(e.cnt2));
    checkVal({p, ".cnt3"}, 32'(a.cnt3), 32'(e.cnt3));
    checkVal({p, ".pass"}, 32'(a.pass), 32'(e.pass));
    checkVal({p, ".busyAtDone"}, 32'(getBusy(sel)), 32'd0);
    if (followUp) begin
      @(posedge clk); #1;
      checkVal({p, ".donePulse"}, 32'(getDone(sel)), 32'd0);
      checkVal({p, ".vecHold"}, 32'(getVec(sel)), 32'd15);
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence.
  initial begin
    int n;
    int holdErr;
    int doneSeen;
    int expV;
    vec_rec_t a;

    cases[0] = '{M_NORMAL,   16'h3232, 16'hCAC2, 16'hB0A0, 5'd6,  5'd7,  5'd5,  3'b111};
    cases[1] = '{M_F2_FAULT, 16'h3232, 16'hC2C2, 16'hB0A0, 5'd6,  5'd6,  5'd5,  3'b101};
    cases[2] = '{M_TIE1,     16'hFFFF, 16'hFFFF, 16'hFFFF, 5'd16, 5'd16, 5'd16, 3'b000};
    cases[3] = '{M_NORMAL,   16'h3232, 16'hCAC2, 16'hB0A0, 5'd6,  5'd7,  5'd5,  3'b111};

    mode0 = M_NORMAL;
    mode1 = M_NORMAL;
    b0.start = 1'b0;
    b1.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    readOut(0, a);
    checkVal("reset.vec", 32'(getVec(0)), 32'd0);
    checkVal("reset.busy", 32'(getBusy(0)), 32'd0);
    checkVal("reset.done", 32'(getDone(0)), 32'd0);
    checkVal("reset.tt1", 32'(a.tt1), 32'd0);
    checkVal("reset.cnt2", 32'(a.cnt2), 32'd0);
    checkVal("reset.pass", 32'(a.pass), 32'd0);
    checkVal("reset.dut1.vec", 32'(getVec(1)), 32'd0);

    // Table-driven sweeps on the SETTLE=0 instance.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, cases[i]);
      waitDone(0, 40, 0, n);
      checkOutput(0, n, 16, 1'b1);
    end

    // SETTLE=3: each code is held for four cycles, done after 64.
    applyStimulus(1, cases[0]);
    holdErr = 0;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      expV = (n / 4 > 15) ? 15 : n / 4;
      if (32'(getVec(1)) != expV) holdErr++;
      if (getDone(1)) break;
    end
    checkVal("settle3.vecStable", 32'(holdErr), 32'd0);
    checkOutput(1, n, 64, 1'b1);

    // Reset at edge 7 of a sweep aborts it with no done pulse.
    mode0 = M_NORMAL;
    b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkVal("midSweep.tt1Partial", 32'(b0.tt1), 32'h0032);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkVal("abort.vec", 32'(getVec(0)), 32'd0);
    checkVal("abort.busy", 32'(getBusy(0)), 32'd0);
    checkVal("abort.tt1", 32'(b0.tt1), 32'd0);
    checkVal("abort.cnt1", 32'(b0.cnt1), 32'd0);
    doneSeen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (b0.done) doneSeen++;
    end
    checkVal("abort.noDone", 32'(doneSeen), 32'd0);
    applyStimulus(0, cases[0]);
    waitDone(0, 40, 0, n);
    checkOutput(0, n, 16, 1'b1);

    // Start at edge 5 is ignored; then start in DONE clears and reruns.
    applyStimulus(0, cases[0]);
    waitDone(0, 40, 5, n);
    checkOutput(0, n, 16, 1'b0);
    applyStimulus(0, cases[0]);
    checkVal("restart.tt1Clear", 32'(b0.tt1), 32'd0);
    checkVal("restart.cnt2Clear", 32'(b0.cnt2), 32'd0);
    checkVal("restart.passClear", 32'(b0.pass), 32'd0);
    waitDone(0, 40, 0, n);
    checkOutput(0, n, 16, 1'b1);

    // Start held high: back-to-back sweeps with one DONE cycle between them.
    mode0 = M_NORMAL;
    sbQ.push_back(cases[0]);
    sbQ.push_back(cases[0]);
    b0.start = 1'b1;
    @(posedge clk); #1;
    waitDone(0, 40, 0, n);
    checkOutput(0, n, 16, 1'b0);
    waitDone(0, 40, 0, n);
    b0.start = 1'b0;
    checkOutput(0, n, 17, 1'b0);
    checkVal("scoreboard.drained", 32'(sbQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
